signal_bar_scheduler: RTL and testbench

- Drives a shared rectangle drawer to paint NUM_BARS status bars on the VGA frame buffer.
- Each bar is drawn in ON_COLOUR or OFF_COLOUR according to its input signal.
- Tracks per-bar dirty bits and redraws only bars whose signal changed, or all bars on request.
- Runs on the system clock and uses a proper start/done handshake with the drawer.

---
 rtl/signal_bar_scheduler.sv | 133 +++++++++++++
 tb/tb_signal_bar_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_bar_scheduler.sv
// Paints NUM_BARS status bars through a shared rectangle drawer, redrawing only
// bars whose synchronised input changed (or all of them on draw_all).
module signal_bar_scheduler #(
    parameter int unsigned NUM_BARS     = 3,
    parameter int unsigned BARS_PER_COL = 2,
    parameter int unsigned X0           = 195,
    parameter int unsigned Y0           = 95,
    parameter int unsigned ROW_PITCH    = 49,
    parameter int unsigned COL_PITCH    = 175,
    parameter int unsigned BAR_W        = 75,
    parameter int unsigned BAR_H        = 10,
    parameter logic [2:0]  ON_COLOUR    = 3'b010,
    parameter logic [2:0]  OFF_COLOUR   = 3'b100,
    parameter int unsigned XW           = 10,
    parameter int unsigned YW           = 9
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_BARS-1:0] signals,
    input  logic                draw_all,
    input  logic                auto_en,
    output logic                rect_start,
    input  logic                rect_done,
    output logic [XW-1:0]       rect_x,
    output logic [YW-1:0]       rect_y,
    output logic [9:0]          rect_w,
    output logic [9:0]          rect_h,
    output logic [2:0]          rect_colour,
    output logic                busy,
    output logic                pass_done
);

    localparam int unsigned PW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} state_t;

    state_t              state, state_next;
    logic [NUM_BARS-1:0] sync_meta, sig_s;
    logic [NUM_BARS-1:0] shown, shown_eff;
    logic [NUM_BARS-1:0] dirty, dirty_next, set_vec;
    logic [1:0]          primed;
    logic [PW-1:0]       ptr, ptr_next, ptr_inc;
    logic                issue_val;
    logic [XW-1:0]       x_tab [NUM_BARS];
    logic [YW-1:0]       y_tab [NUM_BARS];

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_geom
        localparam int unsigned GX = X0 + (g / BARS_PER_COL) * COL_PITCH;
        localparam int unsigned GY = Y0 + (g % BARS_PER_COL) * ROW_PITCH;
        assign x_tab[g] = XW'(GX);
        assign y_tab[g] = YW'(GY);
    end

    assign rect_w = 10'(BAR_W);
    assign rect_h = 10'(BAR_H);

    // shown records the value whose colour was actually issued, and the dirty
    // compare sees that update in the ISSUE cycle, so a bar is neither
    // redrawn twice nor left stale if its input moves between SCAN and ISSUE.
    always_comb begin
        ptr_inc   = (ptr == PW'(NUM_BARS - 1)) ? '0 : ptr + PW'(1);
        shown_eff = shown;
        if (state == ISSUE) shown_eff[ptr] = issue_val;
        set_vec    = {NUM_BARS{draw_all}} | ({NUM_BARS{auto_en}} & (sig_s ^ shown_eff));
        dirty_next = dirty;
        if (state == ISSUE) dirty_next[ptr] = 1'b0;
        dirty_next = dirty_next | set_vec;
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                // primed holds off the first pass until the synchroniser carries real inputs
                if (primed[1] && (|dirty)) state_next = SCAN;
            end
            SCAN: begin
                if (~|dirty)          state_next = IDLE;
                else if (dirty[ptr])  state_next = ISSUE;
                else                  ptr_next   = ptr_inc;
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (rect_done) begin
                    ptr_next   = ptr_inc;
                    state_next = (|dirty_next) ? SCAN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_meta   <= '0;
            sig_s       <= '0;
            primed      <= '0;
            ptr         <= '0;
            shown       <= '0;
            dirty       <= '1;
            issue_val   <= 1'b0;
            rect_start  <= 1'b0;
            rect_x      <= '0;
            rect_y      <= '0;
            rect_colour <= '0;
            busy        <= 1'b0;
            pass_done   <= 1'b0;
        end else begin
            sync_meta  <= signals;
            sig_s      <= sync_meta;
            primed     <= {primed[0], 1'b1};
            ptr        <= ptr_next;
            shown      <= shown_eff;
            dirty      <= dirty_next;
            rect_start <= (state_next == ISSUE);
            busy       <= (state_next != IDLE);
            pass_done  <= (state == WAIT) && (state_next == IDLE);
            if (state_next == ISSUE) begin
                rect_x      <= x_tab[ptr];
                rect_y      <= y_tab[ptr];
                rect_colour <= sig_s[ptr] ? ON_COLOUR : OFF_COLOUR;
                issue_val   <= sig_s[ptr];
            end
        end
    end

endmodule

// File: tb/tb_signal_bar_scheduler.sv
// Directed bench for signal_bar_scheduler: a behavioural drawer acknowledges
// each start after ack_delay cycles and logs every request it receives.
module tb_signal_bar_scheduler;

    logic        clk;
    logic        resetn;
    logic [2:0]  signals;
    logic        draw_all;
    logic        auto_en;
    logic        rect_start;
    logic        rect_done;
    logic [9:0]  rect_x;
    logic [8:0]  rect_y;
    logic [9:0]  rect_w;
    logic [9:0]  rect_h;
    logic [2:0]  rect_colour;
    logic        busy;
    logic        pass_done;

    signal_bar_scheduler #(
        .NUM_BARS(3), .BARS_PER_COL(2), .X0(195), .Y0(95), .ROW_PITCH(49),
        .COL_PITCH(175), .BAR_W(75), .BAR_H(10), .ON_COLOUR(3'b010),
        .OFF_COLOUR(3'b100), .XW(10), .YW(9)
    ) dut (
        .clk(clk), .resetn(resetn), .signals(signals), .draw_all(draw_all),
        .auto_en(auto_en), .rect_start(rect_start), .rect_done(rect_done),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_colour(rect_colour), .busy(busy), .pass_done(pass_done)
    );

    localparam logic [21:0] B0ON  = {10'd195, 9'd95,  3'b010};
    localparam logic [21:0] B0OFF = {10'd195, 9'd95,  3'b100};
    localparam logic [21:0] B1ON  = {10'd195, 9'd144, 3'b010};
    localparam logic [21:0] B1OFF = {10'd195, 9'd144, 3'b100};
    localparam logic [21:0] B2ON  = {10'd370, 9'd95,  3'b010};
    localparam logic [21:0] B2OFF = {10'd370, 9'd95,  3'b100};

    typedef struct packed {
        logic [2:0]       sig;
        logic             auto_en;
        logic             draw_all;
        logic [1:0]       n_starts;
        logic [2:0][21:0] exp_s;
        logic [1:0]       n_pass;
    } vec_t;

    vec_t vecs [6];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // drawer / monitor state (written only by the monitor block)
    logic [21:0] log_q [$];
    int unsigned log_cyc [$];
    int unsigned cyc = 0;
    int unsigned pass_cnt = 0;
    int unsigned stable_err = 0;
    int unsigned dbl_err = 0;
    int unsigned spur_done = 0;
    bit          pending = 0;
    int unsigned cnt = 0;
    logic [21:0] hold;

    // written only by the main block
    int unsigned ack_delay = 4;
    int unsigned spur_reqs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    initial begin
        rect_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rect_done = 1'b0;
            if (!resetn) begin
                pending = 0;
            end else if (pending) begin
                if ({rect_x, rect_y, rect_colour} !== hold) stable_err++;
                cnt--;
                if (cnt == 0) begin
                    rect_done = 1'b1;
                    pending   = 0;
                end
            end
            if (spur_reqs != spur_done) begin
                rect_done = 1'b1;
                spur_done++;
            end
            if (pass_done) pass_cnt++;
            if (rect_start) begin
                if (pending) dbl_err++;
                hold = {rect_x, rect_y, rect_colour};
                log_q.push_back(hold);
                log_cyc.push_back(cyc);
                pending = 1;
                cnt     = ack_delay;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_quiet(input int unsigned budget, output bit ok);
        int unsigned quiet = 0;
        ok = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !pending) quiet++;
            else quiet = 0;
            if (quiet >= 12) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int unsigned base, input int unsigned budget, output bit ok);
        ok = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (log_q.size() > base) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic a, input logic d,
                                input int unsigned n, input logic [21:0] e0,
                                input logic [21:0] e1, input logic [21:0] e2,
                                input int unsigned np);
        vec_t v;
        v.sig      = s;
        v.auto_en  = a;
        v.draw_all = d;
        v.n_starts = 2'(n);
        v.exp_s    = {e2, e1, e0};
        v.n_pass   = 2'(np);
        return v;
    endfunction

    initial begin
        int unsigned base;
        int unsigned pbase;
        int unsigned apply_cyc;
        int unsigned got;
        bit ok;

        vecs[0] = mk(3'b101, 1'b1, 1'b0, 3, B0ON,  B1OFF, B2ON, 1);
        vecs[1] = mk(3'b111, 1'b1, 1'b0, 1, B1ON,  '0,    '0,   1);
        vecs[2] = mk(3'b011, 1'b0, 1'b0, 0, '0,    '0,    '0,   0);
        vecs[3] = mk(3'b011, 1'b0, 1'b1, 3, B2OFF, B0ON,  B1ON, 1);
        vecs[4] = mk(3'b011, 1'b1, 1'b0, 0, '0,    '0,    '0,   0);
        vecs[5] = mk(3'b010, 1'b1, 1'b0, 1, B0OFF, '0,    '0,   1);

        resetn   = 1'b0;
        signals  = 3'b101;
        auto_en  = 1'b1;
        draw_all = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rect_start, rect_x, rect_y, rect_colour, busy, pass_done}, '0);
        check("rect_w", rect_w, 75);
        check("rect_h", rect_h, 10);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            base      = log_q.size();
            pbase     = pass_cnt;
            signals   = vecs[i].sig;
            auto_en   = vecs[i].auto_en;
            apply_cyc = cyc;
            if (vecs[i].draw_all) begin
                draw_all = 1'b1;
                @(negedge clk);
                draw_all = 1'b0;
            end
            wait_quiet(400, ok);
            check($sformatf("v%0d_settle", i), ok, 1);
            got = log_q.size() - base;
            check($sformatf("v%0d_nstarts", i), got, vecs[i].n_starts);
            for (int k = 0; k < int'(vecs[i].n_starts); k++) begin
                if (base + k < log_q.size())
                    check($sformatf("v%0d_start%0d", i, k), log_q[base + k], vecs[i].exp_s[k]);
            end
            check($sformatf("v%0d_pass", i), pass_cnt - pbase, vecs[i].n_pass);
            check($sformatf("v%0d_busy", i), busy, 0);
            if (i == 1 && got > 0)
                check("v1_latency_le8", (log_cyc[base] - apply_cyc) <= 8, 1);
        end

        // bar0 input toggles while its rectangle is in flight
        ack_delay = 20;
        base      = log_q.size();
        pbase     = pass_cnt;
        signals   = 3'b011;
        wait_start(base, 60, ok);
        check("wait_first_start", ok, 1);
        repeat (3) @(negedge clk);
        signals = 3'b010;
        repeat (6) @(negedge clk);
        check("wait_hold_xyc", {rect_x, rect_y, rect_colour}, B0ON);
        check("wait_busy", busy, 1);
        wait_quiet(400, ok);
        check("wait_settle", ok, 1);
        check("wait_nstarts", log_q.size() - base, 2);
        if (log_q.size() >= base + 2) begin
            check("wait_start0", log_q[base], B0ON);
            check("wait_start1", log_q[base + 1], B0OFF);
        end
        check("wait_pass", pass_cnt - pbase, 1);
        ack_delay = 4;

        // spurious done while idle must not disturb state or round-robin pointer
        base  = log_q.size();
        pbase = pass_cnt;
        spur_reqs++;
        repeat (15) @(negedge clk);
        check("spur_nstarts", log_q.size() - base, 0);
        check("spur_busy", busy, 0);
        check("spur_pass", pass_cnt - pbase, 0);
        draw_all = 1'b1;
        @(negedge clk);
        draw_all = 1'b0;
        wait_start(base, 40, ok);
        check("spur_draw_start", ok, 1);
        if (log_q.size() > base) check("spur_first_bar", log_q[base], B1ON);

        // reset while the drawer is busy
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs", {rect_start, rect_x, rect_y, rect_colour, busy, pass_done}, '0);
        base   = log_q.size();
        pbase  = pass_cnt;
        resetn = 1'b1;
        wait_quiet(400, ok);
        check("repaint_settle", ok, 1);
        check("repaint_nstarts", log_q.size() - base, 3);
        if (log_q.size() >= base + 3) begin
            check("repaint_start0", log_q[base],     B0OFF);
            check("repaint_start1", log_q[base + 1], B1ON);
            check("repaint_start2", log_q[base + 2], B2OFF);
        end
        check("repaint_pass", pass_cnt - pbase, 1);
        check("repaint_busy", busy, 0);

        check("output_stability", stable_err, 0);
        check("no_double_start", dbl_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
